alu_pipe_core: RTL and testbench

ALU_PIPE_CORE -- requirements
Module: alu_pipe_core

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_pipe_core_if.sv | 38 +++
 rtl/alu_exec_unit.sv | 76 +++++++
 rtl/alu_pipe_core.sv | 115 +++++++++++
 tb/tb_alu_pipe_core.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and result flag bundle.
// Used by alu_exec_unit, alu_pipe_core and any generated ALU variants.
package alu_pkg;

    localparam int unsigned OpcodeW = 4;

    // Opcode encoding; values 12..15 are illegal.
    typedef enum logic [OpcodeW-1:0] {
        OpMin   = 4'd0,
        OpSrl   = 4'd1,
        OpRor   = 4'd2,
        OpOr    = 4'd3,
        OpAnd   = 4'd4,
        OpPassB = 4'd5,
        OpNor   = 4'd6,
        OpSge   = 4'd7,
        OpSll   = 4'd8,
        OpAdd   = 4'd9,
        OpSub   = 4'd10,
        OpMax   = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic ovf;
        logic sign;
        logic illegal;
    } alu_flags_t;

endpackage

// File: rtl/alu_pipe_core_if.sv
// Handshake bus for alu_pipe_core: request side (in_*) and response side (out_*).
// master drives requests and accepts responses; slave is the ALU core.
interface alu_pipe_core_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 128
);
    localparam int SHW = $clog2(WIDTH);

    logic                in_valid;
    logic                in_ready;
    logic [OpcodeW-1:0]  opcode;
    logic [WIDTH-1:0]    input1;
    logic [WIDTH-1:0]    input2;
    logic [SHW-1:0]      shiftValue;

    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    result;
    logic                carryFlag;
    logic                zeroFlag;
    logic                overFlowFlag;
    logic                signFlag;
    logic                illegalOp;

    modport master (
        output in_valid, opcode, input1, input2, shiftValue, out_ready,
        input  in_ready, out_valid, result, carryFlag, zeroFlag, overFlowFlag,
               signFlag, illegalOp
    );

    modport slave (
        input  in_valid, opcode, input1, input2, shiftValue, out_ready,
        output in_ready, out_valid, result, carryFlag, zeroFlag, overFlowFlag,
               signFlag, illegalOp
    );

endinterface

// File: rtl/alu_exec_unit.sv
// Purely combinational ALU datapath: result and flags from opcode and operands.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [OpcodeW-1:0] opcode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHW-1:0]     shamt,
    output logic [WIDTH-1:0]   result,
    output alu_flags_t         flags
);

    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [2*WIDTH-1:0] ror_dbl;
    logic [SHW-1:0]     srl_idx;
    logic [SHW-1:0]     sll_idx;
    logic               add_ovf;
    logic               sub_ovf;
    logic               sge;

    assign add_full = {1'b0, a} + {1'b0, b};
    // Top bit of the extended difference is the borrow (a < b unsigned).
    assign sub_full = {1'b0, a} - {1'b0, b};
    assign ror_dbl  = {a, a} >> shamt;
    // Index of the last bit shifted out: shamt-1 for right, WIDTH-shamt for left.
    assign srl_idx  = shamt - SHW'(1);
    assign sll_idx  = ~shamt + SHW'(1);
    assign add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
    assign sge      = $signed(a) >= $signed(b);

    // Operation select and per-op carry/overflow; zero/sign derive from the result.
    always_comb begin
        result        = '0;
        flags         = '0;
        case (opcode)
            OpMin:   result = (a < b) ? a : b;
            OpMax:   result = (a > b) ? a : b;
            OpSrl: begin
                result      = a >> shamt;
                flags.carry = (shamt != '0) ? a[srl_idx] : 1'b0;
            end
            OpSll: begin
                result      = a << shamt;
                flags.carry = (shamt != '0) ? a[sll_idx] : 1'b0;
            end
            OpRor: begin
                result      = ror_dbl[WIDTH-1:0];
                flags.carry = ror_dbl[WIDTH-1];
            end
            OpOr:    result = a | b;
            OpAnd:   result = a & b;
            OpPassB: result = b;
            OpNor:   result = ~(a | b);
            OpSge:   result = {{(WIDTH-1){1'b0}}, sge};
            OpAdd: begin
                result      = add_full[WIDTH-1:0];
                flags.carry = add_full[WIDTH];
                flags.ovf   = add_ovf;
            end
            OpSub: begin
                result      = sub_full[WIDTH-1:0];
                flags.carry = sub_full[WIDTH];
                flags.ovf   = sub_ovf;
            end
            default: flags.illegal = 1'b1;
        endcase
        flags.zero = (result == '0);
        flags.sign = result[WIDTH-1];
    end

endmodule

// File: rtl/alu_pipe_core.sv
// Two-stage pipelined ALU with valid/ready handshake on both sides.
// S1 registers the accepted operands, S2 registers the result and flags.
// Optional feature: define ALU_STICKY_OVF_EN to add ovf_clr input and stickyOvf output.
module alu_pipe_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic rst_n,
    alu_pipe_core_if.slave bus
`ifdef ALU_STICKY_OVF_EN
    ,
    input  logic ovf_clr,
    output logic stickyOvf
`endif
);

    logic               s1_valid;
    logic [OpcodeW-1:0] s1_op;
    logic [WIDTH-1:0]   s1_a;
    logic [WIDTH-1:0]   s1_b;
    logic [SHW-1:0]     s1_sh;

    logic               s2_valid;
    logic [WIDTH-1:0]   s2_result;
    alu_flags_t         s2_flags;

    logic [WIDTH-1:0]   exec_result;
    alu_flags_t         exec_flags;

    logic               s2_adv;
    logic               in_ready;
    logic               accept;

    // S2 can take new data when empty or when its current result is leaving.
    assign s2_adv   = !s2_valid || bus.out_ready;
    // rst_n gates ready so the core refuses work while held in reset.
    assign in_ready = rst_n && (!s1_valid || s2_adv);
    assign accept   = bus.in_valid && in_ready;

    alu_exec_unit #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_exec (
        .opcode (s1_op),
        .a      (s1_a),
        .b      (s1_b),
        .shamt  (s1_sh),
        .result (exec_result),
        .flags  (exec_flags)
    );

    // Stage 1: capture operands on acceptance, empty when passed on with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_sh    <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= bus.opcode;
            s1_a     <= bus.input1;
            s1_b     <= bus.input2;
            s1_sh    <= bus.shiftValue;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: register result and flags; hold them while stalled by out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= exec_result;
                s2_flags  <= exec_flags;
            end
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = s2_valid;
    assign bus.result       = s2_result;
    assign bus.carryFlag    = s2_flags.carry;
    assign bus.zeroFlag     = s2_flags.zero;
    assign bus.overFlowFlag = s2_flags.ovf;
    assign bus.signFlag     = s2_flags.sign;
    assign bus.illegalOp    = s2_flags.illegal;

`ifdef ALU_STICKY_OVF_EN
    logic sticky_q;

    // Sticky overflow: set by any transferred overflowing result, set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (s2_valid && bus.out_ready && s2_flags.ovf) begin
            sticky_q <= 1'b1;
        end else if (ovf_clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign stickyOvf = sticky_q;
`endif

endmodule

// File: tb/tb_alu_pipe_core.sv
// Directed self-checking bench for alu_pipe_core at WIDTH 128, 8 and 32.
module tb_alu_pipe_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    alu_pipe_core_if #(.WIDTH(128)) bus128 ();
    alu_pipe_core_if #(.WIDTH(8))   bus8 ();
    alu_pipe_core_if #(.WIDTH(32))  bus32 ();

`ifdef ALU_STICKY_OVF_EN
    logic ovf_clr = 1'b0;
    logic sticky128;
    logic sticky8;
    logic sticky32;
`endif

    alu_pipe_core #(.WIDTH(128)) dut128 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus128)
`ifdef ALU_STICKY_OVF_EN
        ,
        .ovf_clr   (ovf_clr),
        .stickyOvf (sticky128)
`endif
    );

    alu_pipe_core #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus8)
`ifdef ALU_STICKY_OVF_EN
        ,
        .ovf_clr   (ovf_clr),
        .stickyOvf (sticky8)
`endif
    );

    alu_pipe_core #(.WIDTH(32)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus32)
`ifdef ALU_STICKY_OVF_EN
        ,
        .ovf_clr   (ovf_clr),
        .stickyOvf (sticky32)
`endif
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Flag vectors are packed {carry, zero, overflow, sign, illegal}.
    task automatic op8(input string tag, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] sh,
                       input logic [7:0] er, input logic [4:0] ef);
        @(negedge clk);
        bus8.in_valid = 1'b1; bus8.opcode = op; bus8.input1 = a; bus8.input2 = b;
        bus8.shiftValue = sh;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        check({tag, "_early"}, 256'(bus8.out_valid), 256'(0));
        @(posedge clk); #1;
        check({tag, "_valid"}, 256'(bus8.out_valid), 256'(1));
        check({tag, "_res"}, 256'(bus8.result), 256'(er));
        check({tag, "_flags"}, 256'({bus8.carryFlag, bus8.zeroFlag, bus8.overFlowFlag,
                                     bus8.signFlag, bus8.illegalOp}), 256'(ef));
    endtask

    task automatic op32(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] er, input logic [4:0] ef);
        @(negedge clk);
        bus32.in_valid = 1'b1; bus32.opcode = op; bus32.input1 = a; bus32.input2 = b;
        bus32.shiftValue = sh;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        check({tag, "_early"}, 256'(bus32.out_valid), 256'(0));
        @(posedge clk); #1;
        check({tag, "_valid"}, 256'(bus32.out_valid), 256'(1));
        check({tag, "_res"}, 256'(bus32.result), 256'(er));
        check({tag, "_flags"}, 256'({bus32.carryFlag, bus32.zeroFlag, bus32.overFlowFlag,
                                     bus32.signFlag, bus32.illegalOp}), 256'(ef));
    endtask

    task automatic op128(input string tag, input logic [3:0] op, input logic [127:0] a,
                         input logic [127:0] b, input logic [6:0] sh,
                         input logic [127:0] er, input logic [4:0] ef);
        @(negedge clk);
        bus128.in_valid = 1'b1; bus128.opcode = op; bus128.input1 = a; bus128.input2 = b;
        bus128.shiftValue = sh;
        @(posedge clk); #1;
        bus128.in_valid = 1'b0;
        check({tag, "_early"}, 256'(bus128.out_valid), 256'(0));
        @(posedge clk); #1;
        check({tag, "_valid"}, 256'(bus128.out_valid), 256'(1));
        check({tag, "_res"}, 256'(bus128.result), 256'(er));
        check({tag, "_flags"}, 256'({bus128.carryFlag, bus128.zeroFlag, bus128.overFlowFlag,
                                     bus128.signFlag, bus128.illegalOp}), 256'(ef));
    endtask

    // Ten ADDs (i + 0x10) streamed back to back with out_ready low in cycles 3..6.
    task automatic stream_test();
        int   sent = 0;
        int   got = 0;
        int   c = 0;
        logic acc;
        logic xfer;
        logic saw_block = 1'b0;
        while (got < 10 && c < 60) begin
            @(negedge clk);
            bus128.out_ready  = !(c >= 3 && c <= 6);
            bus128.in_valid   = (sent < 10);
            bus128.opcode     = 4'd9;
            bus128.input1     = 128'(sent);
            bus128.input2     = 128'h10;
            bus128.shiftValue = '0;
            #1;
            acc  = bus128.in_valid && bus128.in_ready;
            xfer = bus128.out_valid && bus128.out_ready;
            if (c >= 3 && c <= 6 && !bus128.in_ready) saw_block = 1'b1;
            if (bus128.out_valid)
                check(xfer ? "stream_res" : "stall_hold", 256'(bus128.result),
                      256'(128'h10 + 128'(got)));
            if (c == 7) check("no_bubble", 256'({acc, xfer}), 256'(2'b11));
            @(posedge clk);
            if (acc) sent++;
            if (xfer) got++;
            c++;
        end
        bus128.in_valid  = 1'b0;
        bus128.out_ready = 1'b1;
        check("stream_count", 256'(got), 256'(10));
        check("stream_block", 256'(saw_block), 256'(1));
    endtask

    task automatic reset_midflight();
        int stale = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus128.in_valid = 1'b1; bus128.opcode = 4'd9; bus128.input1 = 128'd1;
        bus128.input2 = 128'd1; bus128.shiftValue = '0;
        @(posedge clk); #1;
        bus128.input1 = 128'd2;
        @(posedge clk); #3;
        bus128.in_valid = 1'b0;
        check("inflight_full", 256'(bus128.out_valid), 256'(1));
        rst_n = 1'b0;
        #1;
        check("rst_ovalid", 256'(bus128.out_valid), 256'(0));
        check("rst_inready", 256'(bus128.in_ready), 256'(0));
        check("rst_result", 256'(bus128.result), 256'(0));
        check("rst_flags", 256'({bus128.carryFlag, bus128.zeroFlag, bus128.overFlowFlag,
                                 bus128.signFlag, bus128.illegalOp}), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_inready", 256'(bus128.in_ready), 256'(1));
        repeat (4) begin
            @(posedge clk); #1;
            if (bus128.out_valid) stale++;
        end
        check("no_stale", 256'(stale), 256'(0));
    endtask

    initial begin
        bus128.in_valid = 1'b0; bus128.opcode = '0; bus128.input1 = '0; bus128.input2 = '0;
        bus128.shiftValue = '0; bus128.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.opcode = '0; bus8.input1 = '0; bus8.input2 = '0;
        bus8.shiftValue = '0; bus8.out_ready = 1'b1;
        bus32.in_valid = 1'b0; bus32.opcode = '0; bus32.input1 = '0; bus32.input2 = '0;
        bus32.shiftValue = '0; bus32.out_ready = 1'b1;

        #2;
        check("reset_ovalid", 256'(bus128.out_valid), 256'(0));
        check("reset_inready", 256'(bus128.in_ready), 256'(0));
        check("reset_result", 256'(bus128.result), 256'(0));
        check("reset_flags", 256'({bus128.carryFlag, bus128.zeroFlag, bus128.overFlowFlag,
                                   bus128.signFlag, bus128.illegalOp}), 256'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_inready", 256'(bus128.in_ready), 256'(1));

        // WIDTH 128
        op128("add_wrap", 4'd9, {128{1'b1}}, 128'd1, 7'd0, 128'd0, 5'b11000);
        op128("sub_neg1", 4'd10, 128'd0, 128'd1, 7'd0, {128{1'b1}}, 5'b10010);
        op128("illegal13", 4'd13, 128'd5, 128'd3, 7'd2, 128'd0, 5'b01001);
        op128("illegal15", 4'd15, 128'd7, 128'd7, 7'd0, 128'd0, 5'b01001);

        // WIDTH 8
        op8("sub8_ovf", 4'd10, 8'h80, 8'h01, 3'd0, 8'h7F, 5'b00100);
        op8("sge8_neg", 4'd7, 8'h80, 8'h01, 3'd0, 8'h00, 5'b01000);
        op8("sge8_pos", 4'd7, 8'h01, 8'h80, 3'd0, 8'h01, 5'b00000);
        op8("min8", 4'd0, 8'h80, 8'h01, 3'd0, 8'h01, 5'b00000);
        op8("max8", 4'd11, 8'h80, 8'h01, 3'd0, 8'h80, 5'b00010);
        op8("add8_ovf", 4'd9, 8'h7F, 8'h01, 3'd0, 8'h80, 5'b00110);
        op8("add8_carry", 4'd9, 8'hFF, 8'h01, 3'd0, 8'h00, 5'b11000);
        op8("sub8_borrow", 4'd10, 8'h01, 8'h02, 3'd0, 8'hFF, 5'b10010);
        op8("sub8_zero", 4'd10, 8'h80, 8'h80, 3'd0, 8'h00, 5'b01000);
        op8("nor8", 4'd6, 8'hF0, 8'h0C, 3'd0, 8'h03, 5'b00000);
        op8("or8", 4'd3, 8'hA0, 8'h05, 3'd0, 8'hA5, 5'b00010);
        op8("and8", 4'd4, 8'hF0, 8'h3C, 3'd0, 8'h30, 5'b00000);
        op8("passb8", 4'd5, 8'h00, 8'h5A, 3'd0, 8'h5A, 5'b00000);
        op8("srl8_sh0", 4'd1, 8'h81, 8'h00, 3'd0, 8'h81, 5'b00010);
        op8("srl8_sh1", 4'd1, 8'h81, 8'h00, 3'd1, 8'h40, 5'b10000);

        // WIDTH 32
        op32("sll32_sh1", 4'd8, 32'h8000_0001, 32'd0, 5'd1, 32'h0000_0002, 5'b10000);
        op32("ror32_sh1", 4'd2, 32'h0000_0001, 32'd0, 5'd1, 32'h8000_0000, 5'b10010);
        op32("ror32_sh0", 4'd2, 32'h1234_5678, 32'd0, 5'd0, 32'h1234_5678, 5'b00000);
        op32("ror32_sh4", 4'd2, 32'h0000_000F, 32'd0, 5'd4, 32'hF000_0000, 5'b10010);
        op32("sll32_sh31", 4'd8, 32'h0000_0003, 32'd0, 5'd31, 32'h8000_0000, 5'b10010);
        op32("sll32_sh0", 4'd8, 32'h0000_0001, 32'd0, 5'd0, 32'h0000_0001, 5'b00000);
        op32("srl32_sh31", 4'd1, 32'h8000_0000, 32'd0, 5'd31, 32'h0000_0001, 5'b00000);

        repeat (2) @(posedge clk);
        stream_test();
        reset_midflight();
        op128("post_rst_add", 4'd9, 128'd20, 128'd22, 7'd0, 128'd42, 5'b00000);

`ifdef ALU_STICKY_OVF_EN
        op128("sticky_ovf_add", 4'd9, {1'b0, {127{1'b1}}}, 128'd1, 7'd0,
              {1'b1, 127'd0}, 5'b00110);
        for (int i = 0; i < 3; i++) begin
            op128("clean_add", 4'd9, 128'(i), 128'd1, 7'd0, 128'(i + 1), 5'b00000);
            check("sticky_held", 256'(sticky128), 256'(1));
        end
        @(negedge clk);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check("sticky_cleared", 256'(sticky128), 256'(0));
        check("sticky8_cleared", 256'(sticky8), 256'(0));
        check("sticky32_cleared", 256'(sticky32), 256'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
